// File: rtl/cla_pkg.sv
// Shared constants and the stage A register layout for the pipelined 16-bit
// carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH  = 16;
  localparam int CLA_GROUP  = 4;
  localparam int CLA_NGROUP = 4;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] p;
    logic        c0;
  } cla_gp_t;

endpackage

// File: rtl/cla_lookahead4.sv
// 4-wide lookahead cell: carries into each position from generate/propagate and
// a carry in, plus the group generate/propagate that summarise the four positions.
module cla_lookahead4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       gout,
  output logic       pout
);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  // gout/pout ignore cin so the group level can use them before any carry is known
  assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pout = &p;

endmodule

// File: rtl/cla16_pipe_adder.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// Stage A holds bit g/p and carry in; stage B resolves carries and holds the result.
module cla16_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_gout,
  output logic             out_pout
);

  if (WIDTH != CLA_WIDTH || GROUP != CLA_GROUP) begin : g_bad_params
    $error("cla16_pipe_adder supports only WIDTH=16, GROUP=4");
  end

  logic    a_valid;
  cla_gp_t a_reg;
  logic    a_en;
  logic    b_en;

  logic [15:0]           cbit;
  logic [CLA_NGROUP-1:0] gg;
  logic [CLA_NGROUP-1:0] gp;
  logic [CLA_NGROUP-1:0] cg;
  logic                  bg;
  logic                  bp;
  logic                  c16;

  // Ready ripples combinationally back from the consumer; no skid buffer
  assign b_en     = ~out_valid | out_ready;
  assign a_en     = ~a_valid | b_en;
  assign in_ready = a_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_reg   <= '0;
    end else if (a_en) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_reg.g  <= in_a & in_b;
        a_reg.p  <= in_a ^ in_b;
        a_reg.c0 <= in_cin;
      end
    end
  end

  for (genvar gi = 0; gi < CLA_NGROUP; gi++) begin : g_bit
    cla_lookahead4 u_bit (
      .g    (a_reg.g[4*gi +: 4]),
      .p    (a_reg.p[4*gi +: 4]),
      .cin  (cg[gi]),
      .c    (cbit[4*gi +: 4]),
      .gout (gg[gi]),
      .pout (gp[gi])
    );
  end

  // Second level turns nibble g/p into the carries C4/C8/C12 feeding each nibble
  cla_lookahead4 u_grp (
    .g    (gg),
    .p    (gp),
    .cin  (a_reg.c0),
    .c    (cg),
    .gout (bg),
    .pout (bp)
  );

  assign c16 = bg | (bp & a_reg.c0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_gout  <= 1'b0;
      out_pout  <= 1'b0;
    end else if (b_en) begin
      out_valid <= a_valid;
      if (a_valid) begin
        out_sum  <= a_reg.p ^ cbit;
        out_cout <= c16;
        out_ovf  <= cbit[15] ^ c16;
        out_gout <= bg;
        out_pout <= bp;
      end
    end
  end

endmodule

// File: tb/tb_cla16_pipe_adder.sv
// Directed and random checks of the pipelined CLA adder against an arithmetic
// reference, with a scoreboard queue matching accepted operands to results.
module tb_cla16_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_gout;
  logic        out_pout;

  int          checkCount = 0;
  int          passCount  = 0;
  int          cycleNum   = 0;
  logic        lastAcc;
  logic        lastPop;
  logic [19:0] sbQ[$];

  always #5 clk = ~clk;

  cla16_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_gout  (out_gout),
    .out_pout  (out_pout)
  );

  // Result packed as {pout, gout, ovf, cout, sum}, derived from plain arithmetic
  function automatic logic [19:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin);
    logic [16:0] s;
    logic [16:0] s0;
    logic        ovf;
    logic        gout;
    logic        pout;
    s    = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    s0   = {1'b0, a} + {1'b0, b};
    ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    gout = s0[16];
    pout = ((a ^ b) == 16'hFFFF);
    return {pout, gout, ovf, s[16], s[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs, sample handshakes before the edge, score pops and pushes
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = ordy;
    #1;
    cycleNum++;
    lastAcc = in_valid && in_ready && !rst;
    lastPop = out_valid && out_ready && !rst;
    if (lastPop) begin
      if (sbQ.size() == 0) checkOutput("unexpected_pop", 32'(1), 32'(0));
      else checkOutput("result", 32'({out_pout, out_gout, out_ovf, out_cout, out_sum}),
                       32'(sbQ.pop_front()));
    end
    if (lastAcc) sbQ.push_back(refModel(a, b, cin));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int          accCycle;
    logic [9:0]  popVec;
    logic [3:0]  accVec;
    logic [15:0] heldSum;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
    checkOutput("reset_outputs", 32'({out_pout, out_gout, out_ovf, out_cout, out_sum}), 32'(0));

    // FFFF + 0001 with latency measurement
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    checkOutput("t1_accept", 32'(lastAcc), 32'(1));
    accCycle = cycleNum;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t1_not_early", 32'(out_valid), 32'(0));
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t1_valid", 32'(out_valid), 32'(1));
    checkOutput("t1_latency", 32'(cycleNum - accCycle), 32'(2));
    checkOutput("t1_sum", 32'({out_pout, out_gout, out_ovf, out_cout, out_sum}),
                32'({1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}));
    idle(2);

    // Signed overflow cases, then full ripple
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h5555, 16'hAAAA, 1'b1, 1'b1);
    idle(3);
    checkOutput("t3_last_result", 32'({out_pout, out_gout, out_ovf, out_cout, out_sum}),
                32'({1'b1, 1'b0, 1'b0, 1'b1, 16'h0000}));

    // Eight back-to-back beats
    popVec = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        checkOutput("t4_in_ready", 32'(lastAcc), 32'(1));
      end else begin
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      end
      popVec[i] = lastPop;
    end
    checkOutput("t4_pop_pattern", 32'(popVec), 32'(10'b11_1111_1100));
    idle(2);

    // Stall with out_ready low for four cycles
    accVec = '0;
    applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    accVec[0] = lastAcc;
    applyStimulus(1'b1, 16'hF000, 16'h2000, 1'b1, 1'b0);
    accVec[1] = lastAcc;
    applyStimulus(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);
    accVec[2] = lastAcc;
    heldSum = out_sum;
    checkOutput("t5_held_valid", 32'(out_valid), 32'(1));
    applyStimulus(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);
    accVec[3] = lastAcc;
    checkOutput("t5_accepts", 32'(accVec), 32'(4'b0011));
    checkOutput("t5_sum_stable", 32'(out_sum), 32'(heldSum));
    checkOutput("t5_first_sum", 32'(out_sum), 32'(16'h2345));
    applyStimulus(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b1);
    checkOutput("t5_release_accept", 32'(lastAcc), 32'(1));
    idle(4);
    checkOutput("t5_drained", 32'(sbQ.size()), 32'(0));

    // Reset with two beats in flight
    applyStimulus(1'b1, 16'hAAAA, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 16'h0002, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    sbQ.delete();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t6_out_valid", 32'(out_valid), 32'(0));
    checkOutput("t6_in_ready", 32'(in_ready), 32'(1));
    checkOutput("t6_outputs", 32'({out_pout, out_gout, out_ovf, out_cout, out_sum}), 32'(0));

    // Random traffic against the reference model
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t6_drain_empty", 32'(sbQ.size()), 32'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
